// File: rtl/rr_arb_pkg.sv
// Shared sizing for the round-robin 4:1 arbiter/mux slice.
// Provides port count, select width, data width and a one-hot helper.
package rr_arb_pkg;

    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    function automatic logic [NUM_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_IN'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// 4-bit 4:1 data mux, built as two 2-bit-wide slices sharing one select.
// Ports: d0..d3 data in, sel index, y selected data.
module mux_4_1
    import rr_arb_pkg::*;
(
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] y
);

    function automatic logic [1:0] mux2b(
        input logic [1:0]       a,
        input logic [1:0]       b,
        input logic [1:0]       c,
        input logic [1:0]       d,
        input logic [SEL_W-1:0] s
    );
        logic [1:0] r;
        case (s)
            2'd0:    r = a;
            2'd1:    r = b;
            2'd2:    r = c;
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0] w_lo;
    logic [1:0] w_hi;

    assign w_lo = mux2b(d0[1:0], d1[1:0], d2[1:0], d3[1:0], sel);
    assign w_hi = mux2b(d0[3:2], d1[3:2], d2[3:2], d3[3:2], sel);
    assign y    = {w_hi, w_lo};

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter feeding a 4:1 mux into a one-entry output register.
// Ports: clk, rst (async high); in_valid/in_ready, d0..d3 per-port request;
// sel grant index; out_valid/out_ready/out_data/out_src output beat.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
#(
    parameter logic [SEL_W-1:0] PTR_INIT = 2'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] in_valid,
    output logic [NUM_IN-1:0] in_ready,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_src
);

    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_src;

    logic              w_accept;
    logic              w_any;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  w_cand;
    logic [DATA_W-1:0] w_mux;

    // Slot is free, or the held beat leaves this same cycle.
    assign w_accept = !r_out_valid | out_ready;

    // Scan from lowest to highest priority so the last hit
    // (offset ptr+1) is the one that sticks.
    always_comb begin
        w_any  = 1'b0;
        w_idx  = r_ptr + 2'd1;
        w_cand = r_ptr + 2'd1;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_cand = r_ptr + SEL_W'(k) + 2'd1;
            if (in_valid[w_cand]) begin
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
    end

    assign in_ready = (w_accept && w_any && !rst) ? onehot(w_idx) : '0;
    assign w_xfer   = |in_ready;
    assign sel      = w_idx;

    mux_4_1 u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (w_idx),
        .y   (w_mux)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= PTR_INIT;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_ptr       <= w_idx;
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_idx;
        end else if (out_ready) begin
            // Drain with no refill; data/src keep their stale values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
